des_key_schedule: RTL and testbench

Iterative DES key schedule generating all sixteen 48-bit round keys from a 64-bit key. It sits directly upstream of the unrolled DES encryption core and drives that core's 768-bit `round_keys` bus. Keys are computed one round per clock. Round 1's key is placed in the most-significant slot, which is the slot the core consumes first.

---
 rtl/des_key_schedule.sv | 156 +++++++++++++++
 tb/tb_des_key_schedule.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit round key per clock, all sixteen
// delivered on a 768-bit bus with K1 (or K16 when decrypting) in the top slot.
module des_key_schedule #(
  parameter bit DECRYPT_CAPABLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  key,
  input  logic         decrypt,
  output logic         busy,
  output logic         done,
  output logic [767:0] round_keys
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_GEN = 2'd1,
    DONE     = 2'd2
  } state_e;

  // FIPS bit i of an N-bit vector lives at index N-i (bit 1 is the MSB).
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
  function automatic logic shift_two(input logic [3:0] rnd);
    logic r;
    case (rnd)
      4'd0, 4'd1, 4'd8, 4'd15: r = 1'b0;
      default:                 r = 1'b1;
    endcase
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [27:0]    c_q, c_d, d_q, d_d;
  logic           mode_q, mode_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [767:0]   round_keys_q, round_keys_d;

  logic [55:0]    pc1_s;
  logic [27:0]    c_rot_s, d_rot_s;
  logic [47:0]    kn_s;
  logic [3:0]     slot_s;

  // Rotated halves, current round key and its destination slot.
  always_comb begin
    pc1_s   = pc1(key);
    c_rot_s = shift_two(rnd_q) ? {c_q[25:0], c_q[27:26]} : {c_q[26:0], c_q[27]};
    d_rot_s = shift_two(rnd_q) ? {d_q[25:0], d_q[27:26]} : {d_q[26:0], d_q[27]};
    kn_s    = pc2({c_rot_s, d_rot_s});
    slot_s  = mode_q ? (4'd15 - rnd_q) : rnd_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    c_d          = c_q;
    d_d          = d_q;
    mode_d       = mode_q;
    round_keys_d = round_keys_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d     = pc1_s[55:28];
          d_d     = pc1_s[27:0];
          mode_d  = decrypt & DECRYPT_CAPABLE;
          rnd_d   = 4'd0;
          state_d = LOAD_GEN;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_GEN: begin
        c_d = c_rot_s;
        d_d = d_rot_s;
        for (int s = 0; s < 16; s++) begin
          round_keys_d[767-48*s -: 48] = (4'(s) == slot_s) ? kn_s
                                                           : round_keys_q[767-48*s -: 48];
        end
        if (rnd_q == 4'd15) begin
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rnd_q        <= 4'd0;
      c_q          <= 28'd0;
      d_q          <= 28'd0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      round_keys_q <= 768'd0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      c_q          <= c_d;
      d_q          <= d_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      round_keys_q <= round_keys_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign round_keys = round_keys_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: FIPS example keys, decrypt order, weak
// keys, parity, start-while-busy, mid-run reset, retrigger and a full DES encryption.
module tb_des_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [63:0]  key;
  logic         decrypt;
  logic         busy;
  logic         done;
  logic [767:0] round_keys;

  int tests = 0;
  int fails = 0;

  des_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .decrypt    (decrypt),
    .busy       (busy),
    .done       (done),
    .round_keys (round_keys)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;

  localparam logic [47:0] KEXP [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
  };
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // DES encryption using the sixteen keys from a round_keys bus (slot 0 first).
  function automatic logic [63:0] des_enc(input logic [63:0] m, input logic [767:0] rk);
    logic [63:0] ip, pre, res;
    logic [31:0] l, r, f, so, t;
    logic [47:0] e;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 64; i++) ip[63-i] = m[64-IP_T[i]];
    l = ip[63:32];
    r = ip[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int j = 0; j < 48; j++) e[47-j] = r[32-E_T[j]];
      e = e ^ rk[767-48*rd -: 48];
      for (int sb = 0; sb < 8; sb++) begin
        b   = e[47-6*sb -: 6];
        idx = 16 * int'({b[5], b[0]}) + int'(b[4:1]);
        so[31-4*sb -: 4] = 4'(SBOX[sb][idx]);
      end
      for (int j = 0; j < 32; j++) f[31-j] = so[32-P_T[j]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then time the run to done and check the pulse ends.
  task automatic run(input logic [63:0] k, input logic dec, input string tag);
    int n;
    @(negedge clk);
    key = k; decrypt = dec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({tag, " busy+1"}, {767'd0, busy}, 768'd1);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 768'(n), 768'd17);
    @(negedge clk);
    chk({tag, " done pulse"}, {766'd0, busy, done}, 768'd0);
  endtask

  logic [767:0] fips_ref, dec_ref, prev;
  int           n, busy_cnt, done_cnt, first_done, second_done;

  initial begin
    for (int i = 0; i < 16; i++) begin
      fips_ref[767-48*i -: 48] = KEXP[i];
      dec_ref[767-48*i -: 48]  = KEXP[15-i];
    end
    rst_n = 1'b0; start = 1'b0; key = 64'd0; decrypt = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, done, round_keys}, 770'd0);
    rst_n = 1'b1;

    run(FIPS_KEY, 1'b0, "fips");
    chk("fips K1", {720'd0, round_keys[767:720]}, {720'd0, 48'h1B02EFFC7072});
    chk("fips K2", {720'd0, round_keys[719:672]}, {720'd0, 48'h79AED9DBC9E5});
    chk("fips K16", {720'd0, round_keys[47:0]}, {720'd0, 48'hCB3D8B0E17F5});
    chk("fips all", round_keys, fips_ref);
    chk("integration", {704'd0, des_enc(64'h0123456789ABCDEF, round_keys)},
        {704'd0, 64'h85E813540F0AB405});
    prev = round_keys;

    run(FIPS_KEY, 1'b1, "decrypt");
    chk("dec slot0", {720'd0, round_keys[767:720]}, {720'd0, 48'hCB3D8B0E17F5});
    chk("dec slot15", {720'd0, round_keys[47:0]}, {720'd0, 48'h1B02EFFC7072});
    for (int s = 0; s < 16; s++)
      chk($sformatf("dec mirror %0d", s), {720'd0, round_keys[767-48*s -: 48]},
          {720'd0, prev[767-48*(15-s) -: 48]});

    run(64'h0101010101010101, 1'b0, "weak0");
    chk("weak0 keys", round_keys, 768'd0);
    run(64'hFEFEFEFEFEFEFEFE, 1'b0, "weak1");
    chk("weak1 keys", round_keys, {16{48'hFFFFFFFFFFFF}});
    run(FIPS_KEY ^ 64'h0101010101010101, 1'b0, "parity all");
    chk("parity all keys", round_keys, fips_ref);
    run(FIPS_KEY ^ 64'h0100000000000000, 1'b0, "parity bit8");
    chk("parity bit8 keys", round_keys, fips_ref);

    // Second start at +5 must be ignored.
    @(negedge clk);
    key = FIPS_KEY; decrypt = 1'b0; start = 1'b1;
    busy_cnt = 0; done_cnt = 0; first_done = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 5) begin
        key = 64'hFEFEFEFEFEFEFEFE; start = 1'b1;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
      if (n == 17) chk("busy-start busy@17", {767'd0, busy}, 768'd1);
    end
    chk("busy-start busy cycles", 768'(busy_cnt), 768'd17);
    chk("busy-start done count", 768'(done_cnt), 768'd1);
    chk("busy-start done time", 768'(first_done), 768'd17);
    chk("busy-start keys", round_keys, fips_ref);

    // Reset at cycle +8 aborts the run.
    @(negedge clk);
    key = 64'hFEFEFEFEFEFEFEFE; start = 1'b1;
    for (n = 1; n < 8; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun reset", {busy, done, round_keys}, 770'd0);
    start = 1'b1; key = FIPS_KEY;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("start during reset dropped", {766'd0, busy, done}, 768'd0);
    run(FIPS_KEY, 1'b0, "after reset");
    chk("after reset keys", round_keys, fips_ref);

    // Held start retriggers every 18 cycles.
    @(negedge clk);
    key = 64'h0101010101010101; start = 1'b1;
    first_done = 0; second_done = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
      end
    end
    start = 1'b0;
    chk("retrigger first", 768'(first_done), 768'd17);
    chk("retrigger second", 768'(second_done), 768'd35);
    repeat (40) @(negedge clk);
    chk("retrigger keys", round_keys, 768'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
